// File: rtl/gray_decoder_monitor.sv
// Gray-count receiver: decodes each accepted Gray sample to binary and checks
// that consecutive samples differ by one legal single-bit step.
module gray_decoder_monitor #(
    parameter int WIDTH      = 3,
    parameter int RESYNC_LEN = 2,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     gray_in,
    input  logic                 gray_valid,
    input  logic                 err_clr,
    output logic [WIDTH-1:0]     bin_out,
    output logic                 bin_valid,
    output logic                 dir,
    output logic                 hold,
    output logic                 step_err,
    output logic                 locked,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int DIST_W = $clog2(WIDTH + 1);
    localparam logic [DIST_W-1:0]    DIST_ZERO     = DIST_W'(0);
    localparam logic [DIST_W-1:0]    DIST_ONE      = DIST_W'(1);
    localparam logic [3:0]           RESYNC_TARGET = 4'(RESYNC_LEN);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX       = {ERR_CNT_W{1'b1}};
    localparam logic [ERR_CNT_W-1:0] ERR_ZERO      = {ERR_CNT_W{1'b0}};
    localparam logic [ERR_CNT_W-1:0] ERR_ONE       = ERR_CNT_W'(1);

    typedef enum logic [1:0] {
        UNLOCK = 2'd0,
        LOCK   = 2'd1,
        RESYNC = 2'd2
    } state_t;

    state_t               state_r;
    logic [WIDTH-1:0]     prev_r;
    logic [3:0]           good_cnt_r;

    logic [DIST_W-1:0]    dist_s;
    logic [WIDTH-1:0]     bin_new_s;
    logic [WIDTH-1:0]     bin_prev_s;
    logic [WIDTH-1:0]     bin_inc_s;
    logic                 up_s;
    logic                 err_event_s;
    logic [ERR_CNT_W-1:0] err_base_s;
    logic [ERR_CNT_W-1:0] err_next_s;

    function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [DIST_W-1:0] hamming(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0]  d;
        logic [DIST_W-1:0] n;
        d = a ^ b;
        n = DIST_ZERO;
        for (int i = 0; i < WIDTH; i++) begin
            n = n + DIST_W'(d[i]);
        end
        return n;
    endfunction

    // Step classification and next error count for the current sample.
    always_comb begin
        dist_s      = hamming(gray_in, prev_r);
        bin_new_s   = gray_to_bin(gray_in);
        bin_prev_s  = gray_to_bin(prev_r);
        bin_inc_s   = bin_prev_s + WIDTH'(1);
        up_s        = (bin_new_s == bin_inc_s);
        err_event_s = gray_valid && (state_r != UNLOCK) && (dist_s > DIST_ONE);
        // Clear takes effect before a coincident increment.
        if (err_clr) begin
            err_base_s = ERR_ZERO;
        end else begin
            err_base_s = err_count;
        end
        if (err_event_s && (err_base_s != ERR_MAX)) begin
            err_next_s = err_base_s + ERR_ONE;
        end else begin
            err_next_s = err_base_s;
        end
    end

    // Lock FSM, reference sample and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= UNLOCK;
            prev_r     <= {WIDTH{1'b0}};
            good_cnt_r <= 4'd0;
            bin_out    <= {WIDTH{1'b0}};
            bin_valid  <= 1'b0;
            dir        <= 1'b1;
            hold       <= 1'b0;
            step_err   <= 1'b0;
            locked     <= 1'b0;
            err_count  <= ERR_ZERO;
        end else begin
            bin_valid <= 1'b0;
            hold      <= 1'b0;
            step_err  <= 1'b0;
            err_count <= err_next_s;
            if (gray_valid) begin
                bin_out   <= bin_new_s;
                bin_valid <= 1'b1;
                prev_r    <= gray_in;
                case (state_r)
                    UNLOCK: begin
                        state_r <= LOCK;
                        locked  <= 1'b1;
                    end
                    LOCK: begin
                        if (dist_s == DIST_ZERO) begin
                            hold <= 1'b1;
                        end else if (dist_s == DIST_ONE) begin
                            dir <= up_s;
                        end else begin
                            step_err   <= 1'b1;
                            good_cnt_r <= 4'd0;
                            state_r    <= RESYNC;
                            locked     <= 1'b0;
                        end
                    end
                    RESYNC: begin
                        if (dist_s == DIST_ZERO) begin
                            hold <= 1'b1;
                        end else if (dist_s == DIST_ONE) begin
                            dir <= up_s;
                            if ((good_cnt_r + 4'd1) == RESYNC_TARGET) begin
                                good_cnt_r <= 4'd0;
                                state_r    <= LOCK;
                                locked     <= 1'b1;
                            end else begin
                                good_cnt_r <= good_cnt_r + 4'd1;
                            end
                        end else begin
                            step_err   <= 1'b1;
                            good_cnt_r <= 4'd0;
                        end
                    end
                    default: begin
                        state_r    <= UNLOCK;
                        good_cnt_r <= 4'd0;
                        locked     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gray_decoder_monitor.sv
// Bench for gray_decoder_monitor: directed vector table, saturation and reset
// sequences, then random traffic against a behavioural model.
module tb_gray_decoder_monitor;

    localparam int RESYNC_LEN = 2;
    localparam int ERR_MAX    = 255;

    logic       clk;
    logic       rst;
    logic [2:0] gray_in;
    logic       gray_valid;
    logic       err_clr;
    logic [2:0] bin_out;
    logic       bin_valid;
    logic       dir;
    logic       hold;
    logic       step_err;
    logic       locked;
    logic [7:0] err_count;

    int tests = 0;
    int fails = 0;

    // Model state: 0 = unlocked, 1 = locked, 2 = resyncing.
    int m_state, m_prev, m_cnt, m_bin, m_bv, m_dir, m_hold, m_se, m_err;

    typedef struct {
        logic       v;
        logic [2:0] g;
        logic       c;
        int bin; int bv; int dir; int hold; int se; int lk; int err;
    } vec_t;

    vec_t tbl[19];

    gray_decoder_monitor dut (
        .clk(clk), .rst(rst), .gray_in(gray_in), .gray_valid(gray_valid),
        .err_clr(err_clr), .bin_out(bin_out), .bin_valid(bin_valid), .dir(dir),
        .hold(hold), .step_err(step_err), .locked(locked), .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int enc(input int n);
        return (n ^ (n >> 1)) & 7;
    endfunction

    function automatic int dec(input int g);
        int r;
        r = 0;
        for (int k = 0; k < 8; k++) begin
            if (enc(k) == g) r = k;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_state = 0; m_prev = 0; m_cnt = 0; m_bin = 0; m_bv = 0;
        m_dir = 1; m_hold = 0; m_se = 0; m_err = 0;
    endtask

    task automatic model_step(input logic v, input int g, input logic c);
        int d, n, p;
        m_bv = 0; m_hold = 0; m_se = 0;
        if (c) m_err = 0;
        if (v) begin
            n = dec(g);
            p = dec(m_prev);
            d = $countones(g ^ m_prev);
            m_bv = 1;
            if (m_state == 0) begin
                m_state = 1;
            end else if (d == 0) begin
                m_hold = 1;
            end else if (d == 1) begin
                m_dir = (n == (p + 1) % 8) ? 1 : 0;
                if (m_state == 2) begin
                    m_cnt++;
                    if (m_cnt == RESYNC_LEN) begin
                        m_state = 1;
                        m_cnt = 0;
                    end
                end
            end else begin
                m_se = 1;
                if (m_err < ERR_MAX) m_err++;
                m_cnt = 0;
                m_state = 2;
            end
            m_bin = n;
            m_prev = g;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".bin_out"},   int'(bin_out),   m_bin);
        chk({tag, ".bin_valid"}, int'(bin_valid), m_bv);
        chk({tag, ".dir"},       int'(dir),       m_dir);
        chk({tag, ".hold"},      int'(hold),      m_hold);
        chk({tag, ".step_err"},  int'(step_err),  m_se);
        chk({tag, ".locked"},    int'(locked),    (m_state == 1) ? 1 : 0);
        chk({tag, ".err_count"}, int'(err_count), m_err);
    endtask

    task automatic step(input logic v, input logic [2:0] g, input logic c);
        @(negedge clk);
        gray_valid = v;
        gray_in    = g;
        err_clr    = c;
        @(posedge clk);
        #1;
        model_step(v, int'(g), c);
    endtask

    initial begin
        int g, r, p;
        logic [2:0] gsel;

        // v, gray, clr | bin, bin_valid, dir, hold, step_err, locked, err_count
        tbl[0]  = '{1'b1, 3'b000, 1'b0, 0, 1, 1, 0, 0, 1, 0};
        tbl[1]  = '{1'b1, 3'b001, 1'b0, 1, 1, 1, 0, 0, 1, 0};
        tbl[2]  = '{1'b1, 3'b011, 1'b0, 2, 1, 1, 0, 0, 1, 0};
        tbl[3]  = '{1'b1, 3'b010, 1'b0, 3, 1, 1, 0, 0, 1, 0};
        tbl[4]  = '{1'b1, 3'b110, 1'b0, 4, 1, 1, 0, 0, 1, 0};
        tbl[5]  = '{1'b1, 3'b111, 1'b0, 5, 1, 1, 0, 0, 1, 0};
        tbl[6]  = '{1'b1, 3'b101, 1'b0, 6, 1, 1, 0, 0, 1, 0};
        tbl[7]  = '{1'b1, 3'b100, 1'b0, 7, 1, 1, 0, 0, 1, 0};
        tbl[8]  = '{1'b1, 3'b000, 1'b0, 0, 1, 1, 0, 0, 1, 0};
        tbl[9]  = '{1'b1, 3'b100, 1'b0, 7, 1, 0, 0, 0, 1, 0};
        tbl[10] = '{1'b1, 3'b101, 1'b0, 6, 1, 0, 0, 0, 1, 0};
        tbl[11] = '{1'b1, 3'b111, 1'b0, 5, 1, 0, 0, 0, 1, 0};
        tbl[12] = '{1'b1, 3'b010, 1'b0, 3, 1, 0, 0, 1, 0, 1};
        tbl[13] = '{1'b1, 3'b011, 1'b0, 2, 1, 0, 0, 0, 0, 1};
        tbl[14] = '{1'b1, 3'b001, 1'b0, 1, 1, 0, 0, 0, 1, 1};
        tbl[15] = '{1'b1, 3'b001, 1'b0, 1, 1, 0, 1, 0, 1, 1};
        tbl[16] = '{1'b0, 3'b110, 1'b0, 1, 0, 0, 0, 0, 1, 1};
        tbl[17] = '{1'b1, 3'b000, 1'b0, 0, 1, 0, 0, 0, 1, 1};
        tbl[18] = '{1'b0, 3'b000, 1'b1, 0, 0, 0, 0, 0, 1, 0};

        rst = 1'b0; gray_in = 3'b000; gray_valid = 1'b0; err_clr = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset.bin_out",   int'(bin_out),   0);
        chk("reset.bin_valid", int'(bin_valid), 0);
        chk("reset.dir",       int'(dir),       1);
        chk("reset.locked",    int'(locked),    0);
        chk("reset.err_count", int'(err_count), 0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 19; i++) begin
            step(tbl[i].v, tbl[i].g, tbl[i].c);
            chk($sformatf("vec%0d.bin_out", i),   int'(bin_out),   tbl[i].bin);
            chk($sformatf("vec%0d.bin_valid", i), int'(bin_valid), tbl[i].bv);
            chk($sformatf("vec%0d.dir", i),       int'(dir),       tbl[i].dir);
            chk($sformatf("vec%0d.hold", i),      int'(hold),      tbl[i].hold);
            chk($sformatf("vec%0d.step_err", i),  int'(step_err),  tbl[i].se);
            chk($sformatf("vec%0d.locked", i),    int'(locked),    tbl[i].lk);
            chk($sformatf("vec%0d.err_count", i), int'(err_count), tbl[i].err);
        end

        // Saturation: 300 illegal steps alternating 011 / 000.
        for (int i = 0; i < 300; i++) begin
            gsel = (i % 2 == 0) ? 3'b011 : 3'b000;
            step(1'b1, gsel, 1'b0);
            chk_model("sat");
        end
        chk("sat.err_count_max", int'(err_count), 255);
        step(1'b1, 3'b011, 1'b1);
        chk("clr_with_err.err_count", int'(err_count), 1);
        chk("clr_with_err.step_err",  int'(step_err),  1);
        step(1'b0, 3'b011, 1'b1);
        chk("clr_alone.err_count", int'(err_count), 0);

        // Asynchronous reset between edges, then first sample is never flagged.
        step(1'b1, 3'b001, 1'b0);
        @(negedge clk);
        gray_valid = 1'b0;
        err_clr    = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        chk("async_rst.bin_out",   int'(bin_out),   0);
        chk("async_rst.dir",       int'(dir),       1);
        chk("async_rst.step_err",  int'(step_err),  0);
        chk("async_rst.locked",    int'(locked),    0);
        chk("async_rst.err_count", int'(err_count), 0);
        @(negedge clk);
        rst = 1'b1;
        step(1'b1, 3'b110, 1'b0);
        chk("post_rst.step_err", int'(step_err), 0);
        chk("post_rst.locked",   int'(locked),   1);
        chk("post_rst.bin_out",  int'(bin_out),  4);

        // Random traffic, mostly legal steps.
        for (int i = 0; i < 600; i++) begin
            p = dec(m_prev);
            r = int'($urandom_range(0, 9));
            if (r <= 4)      g = enc((p + 1) % 8);
            else if (r <= 6) g = enc((p + 7) % 8);
            else if (r == 7) g = m_prev;
            else             g = int'($urandom_range(0, 7));
            step((r == 9) ? 1'b0 : 1'b1, 3'(g), ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0);
            chk_model("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
